// File: rtl/instr_mem_responder.sv
// Instruction memory responder: synchronous word store with a one-entry read
// pipe feeding a two-entry in-order response FIFO, flushable on branches.
module instr_mem_responder #(
    parameter int MEM_DEPTH  = 256,
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        flush,
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [31:0] rsp_addr,
    output logic        rsp_err,
    output logic [15:0] err_count
);

    localparam int          AW       = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [32:0] DEPTH_W  = 33'(MEM_DEPTH);
    localparam logic [1:0]  CAPACITY = 2'(FIFO_DEPTH);

    logic [31:0]   mem [MEM_DEPTH];

    logic          pipe_valid;
    logic          pipe_err;
    logic [31:0]   pipe_addr;
    logic [31:0]   pipe_word;

    logic [31:0]   fifo_data [2];
    logic [31:0]   fifo_addr [2];
    logic [1:0]    fifo_err;
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    fifo_count;

    logic          rd_in_range;
    logic          wr_in_range;
    logic [AW-1:0] rd_idx;
    logic [AW-1:0] wr_idx;
    logic [1:0]    occupancy;
    logic          accept;
    logic          push;
    logic          pop;

    assign rd_in_range = {1'b0, req_addr} < DEPTH_W;
    assign wr_in_range = {1'b0, wr_addr} < DEPTH_W;
    assign rd_idx      = req_addr[AW-1:0];
    assign wr_idx      = wr_addr[AW-1:0];

    // Readiness looks only at registered occupancy, so a same-cycle pop does not free a slot.
    assign occupancy = {1'b0, pipe_valid} + fifo_count;
    assign req_ready = reset && !flush && (occupancy < CAPACITY);
    assign accept    = req_valid && req_ready;
    assign push      = pipe_valid && !flush;
    assign pop       = rsp_valid && rsp_ready && !flush;

    assign rsp_valid = (fifo_count != 2'd0);
    assign rsp_data  = rsp_valid ? fifo_data[rd_ptr] : 32'd0;
    assign rsp_addr  = rsp_valid ? fifo_addr[rd_ptr] : 32'd0;
    assign rsp_err   = rsp_valid && fifo_err[rd_ptr];

    // Storage survives reset; a same-edge write is not seen by the read (old data wins).
    always_ff @(posedge clk) begin
        if (wr_en && wr_in_range) begin
            mem[wr_idx] <= wr_data;
        end
        if (accept) begin
            pipe_word <= mem[rd_idx];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipe_valid <= 1'b0;
            pipe_addr  <= 32'd0;
            pipe_err   <= 1'b0;
        end else begin
            pipe_valid <= accept;
            if (accept) begin
                pipe_addr <= req_addr;
                pipe_err  <= !rd_in_range;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= pipe_err ? 32'd0 : pipe_word;
            fifo_addr[wr_ptr] <= pipe_addr;
            fifo_err[wr_ptr]  <= pipe_err;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_count <= 2'd0;
        end else if (flush) begin
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_count <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_count <= 16'd0;
        end else if (pop && fifo_err[rd_ptr] && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 16'd1;
        end
    end

endmodule
